irq_request_controller: RTL and testbench



---
 rtl/irq_ctrl_pkg.sv | 17 +
 rtl/priority_encoder_8to3.sv | 17 +
 rtl/irq_request_controller.sv | 86 ++++++++
 tb/tb_irq_request_controller.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared constants and state encoding for the interrupt request controller.
package irq_ctrl_pkg;

   localparam int N    = 8;
   localparam int ID_W = 3;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PRESENT = 1'b1
   } irq_state_e;

   function automatic logic [N-1:0] id_onehot(input logic [ID_W-1:0] id);
      id_onehot = '0;
      id_onehot[id] = 1'b1;
   endfunction

endpackage

// File: rtl/priority_encoder_8to3.sv
// Combinational 8-to-3 priority encoder; the highest set input index wins.
module priority_encoder_8to3 (
   input  logic [7:0] in,
   output logic [2:0] out,
   output logic       valid
);

   always_comb begin
      out   = '0;
      valid = |in;
      // Ascending scan so the last (highest) set bit overrides lower ones.
      for (int i = 0; i < 8; i++) begin
         if (in[i]) out = i[2:0];
      end
   end

endmodule

// File: rtl/irq_request_controller.sv
// Captures rising edges on request lines into sticky pending bits and presents
// the highest-priority unmasked one as an ID through a valid/ack handshake.
module irq_request_controller
   import irq_ctrl_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req_in,
   input  logic [N-1:0]    mask,
   output logic            irq_valid,
   output logic [ID_W-1:0] irq_id,
   input  logic            irq_ack,
   output logic [N-1:0]    pending,
   output logic [N-1:0]    missed
);

   // Handshake: irq_id is transferred on a cycle where irq_valid and irq_ack
   // are both high; irq_id stays constant while irq_valid is high, and
   // irq_ack is ignored whenever irq_valid is low.

   logic [N-1:0]    req_q;
   logic [N-1:0]    rise;
   logic [N-1:0]    clr;
   logic            ack_fire;
   logic [N-1:0]    enc_in;
   logic [ID_W-1:0] enc_out;
   logic            enc_valid;
   irq_state_e      state, state_nxt;
   logic [ID_W-1:0] id_nxt;

   assign rise     = req_in & ~req_q;
   assign ack_fire = irq_valid & irq_ack;
   assign clr      = ack_fire ? id_onehot(irq_id) : '0;
   assign enc_in   = pending & ~mask;

   priority_encoder_8to3 u_enc (
      .in    (enc_in),
      .out   (enc_out),
      .valid (enc_valid)
   );

   // A rise on the bit being cleared re-arms it, and is not counted as missed.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_q   <= '0;
         pending <= '0;
         missed  <= '0;
      end else begin
         req_q   <= req_in;
         pending <= (pending & ~clr) | rise;
         missed  <= missed | (rise & pending & ~clr);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         irq_id <= '0;
      end else begin
         state  <= state_nxt;
         irq_id <= id_nxt;
      end
   end

   // The ID is captured only on entry to PRESENT, so no preemption or mask
   // change can disturb it while it is presented.
   always_comb begin
      state_nxt = state;
      id_nxt    = irq_id;
      case (state)
         ST_IDLE: begin
            if (enc_valid) begin
               state_nxt = ST_PRESENT;
               id_nxt    = enc_out;
            end
         end
         ST_PRESENT: begin
            if (irq_ack) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign irq_valid = (state == ST_PRESENT);

endmodule

// File: tb/tb_irq_request_controller.sv
// Directed bench for irq_request_controller: vector table plus hand sequences.
module tb_irq_request_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req_in;
   logic [7:0] mask;
   logic       irq_valid;
   logic [2:0] irq_id;
   logic       irq_ack;
   logic [7:0] pending;
   logic [7:0] missed;

   int n_checks = 0;
   int n_fail   = 0;

   logic [2:0] exp_q[$];

   typedef struct {
      logic [7:0] req;
      logic [7:0] msk;
      logic       ack;
      logic       e_valid;
      logic [2:0] e_id;
      logic [7:0] e_pend;
      logic [7:0] e_missed;
   } vec_t;

   vec_t vecs[27];

   irq_request_controller dut (
      .clk       (clk),
      .rst       (rst),
      .req_in    (req_in),
      .mask      (mask),
      .irq_valid (irq_valid),
      .irq_id    (irq_id),
      .irq_ack   (irq_ack),
      .pending   (pending),
      .missed    (missed)
   );

   // clock
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [7:0] req, input logic [7:0] msk, input logic ack,
                               input logic ev, input logic [2:0] eid, input logic [7:0] ep,
                               input logic [7:0] em);
      vec_t v;
      v.req = req; v.msk = msk; v.ack = ack;
      v.e_valid = ev; v.e_id = eid; v.e_pend = ep; v.e_missed = em;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic [7:0] r, input logic [7:0] m, input logic a);
      req_in  = r;
      mask    = m;
      irq_ack = a;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic ev, input logic [2:0] eid,
                          input logic [7:0] ep, input logic [7:0] em);
      chk({tag, ".valid"},   {31'd0, irq_valid}, {31'd0, ev});
      chk({tag, ".id"},      {29'd0, irq_id},    {29'd0, eid});
      chk({tag, ".pending"}, {24'd0, pending},   {24'd0, ep});
      chk({tag, ".missed"},  {24'd0, missed},    {24'd0, em});
   endtask

   // scoreboard: every accepted ID must match the next expected one
   always @(negedge clk) begin
      if (irq_valid && irq_ack) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb.unexpected: got id %0d expected none", irq_id);
         end else begin
            chk("sb.id", {29'd0, irq_id}, {29'd0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      int waited;

      vecs[0]  = mk(8'h04, 8'h00, 1'b0, 1'b0, 3'd0, 8'h04, 8'h00);
      vecs[1]  = mk(8'h00, 8'h00, 1'b0, 1'b1, 3'd2, 8'h04, 8'h00);
      vecs[2]  = mk(8'h00, 8'h00, 1'b1, 1'b0, 3'd2, 8'h00, 8'h00);
      vecs[3]  = mk(8'hE0, 8'h00, 1'b0, 1'b0, 3'd2, 8'hE0, 8'h00);
      vecs[4]  = mk(8'hE0, 8'h00, 1'b0, 1'b1, 3'd7, 8'hE0, 8'h00);
      vecs[5]  = mk(8'h00, 8'h00, 1'b1, 1'b0, 3'd7, 8'h60, 8'h00);
      vecs[6]  = mk(8'h00, 8'h00, 1'b0, 1'b1, 3'd6, 8'h60, 8'h00);
      vecs[7]  = mk(8'h00, 8'h00, 1'b1, 1'b0, 3'd6, 8'h20, 8'h00);
      vecs[8]  = mk(8'h00, 8'h00, 1'b0, 1'b1, 3'd5, 8'h20, 8'h00);
      vecs[9]  = mk(8'h00, 8'h00, 1'b1, 1'b0, 3'd5, 8'h00, 8'h00);
      vecs[10] = mk(8'h10, 8'h10, 1'b0, 1'b0, 3'd5, 8'h10, 8'h00);
      vecs[11] = mk(8'h00, 8'h10, 1'b0, 1'b0, 3'd5, 8'h10, 8'h00);
      vecs[12] = mk(8'h00, 8'h10, 1'b0, 1'b0, 3'd5, 8'h10, 8'h00);
      vecs[13] = mk(8'h10, 8'h10, 1'b0, 1'b0, 3'd5, 8'h10, 8'h10);
      vecs[14] = mk(8'h00, 8'h00, 1'b0, 1'b1, 3'd4, 8'h10, 8'h10);
      vecs[15] = mk(8'h00, 8'h00, 1'b1, 1'b0, 3'd4, 8'h00, 8'h10);
      vecs[16] = mk(8'h00, 8'h00, 1'b1, 1'b0, 3'd4, 8'h00, 8'h10);
      vecs[17] = mk(8'h01, 8'h00, 1'b0, 1'b0, 3'd4, 8'h01, 8'h10);
      vecs[18] = mk(8'h00, 8'h00, 1'b0, 1'b1, 3'd0, 8'h01, 8'h10);
      vecs[19] = mk(8'h01, 8'h00, 1'b1, 1'b0, 3'd0, 8'h01, 8'h10);
      vecs[20] = mk(8'h00, 8'h00, 1'b0, 1'b1, 3'd0, 8'h01, 8'h10);
      vecs[21] = mk(8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 8'h10);
      vecs[22] = mk(8'h08, 8'h00, 1'b0, 1'b0, 3'd0, 8'h08, 8'h10);
      vecs[23] = mk(8'h00, 8'h00, 1'b0, 1'b1, 3'd3, 8'h08, 8'h10);
      vecs[24] = mk(8'h00, 8'h08, 1'b0, 1'b1, 3'd3, 8'h08, 8'h10);
      vecs[25] = mk(8'h00, 8'h08, 1'b1, 1'b0, 3'd3, 8'h00, 8'h10);
      vecs[26] = mk(8'h00, 8'h00, 1'b0, 1'b0, 3'd3, 8'h00, 8'h10);

      exp_q = '{3'd2, 3'd7, 3'd6, 3'd5, 3'd4, 3'd0, 3'd0, 3'd3, 3'd1, 3'd7, 3'd2};

      // reset
      rst = 1'b1;
      req_in = '0;
      mask = '0;
      irq_ack = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step(8'h00, 8'h00, 1'b0);
         chk_out($sformatf("reset%0d", i), 1'b0, 3'd0, 8'h00, 8'h00);
      end
      rst = 1'b0;

      for (int i = 0; i < 27; i++) begin
         step(vecs[i].req, vecs[i].msk, vecs[i].ack);
         chk_out($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_id,
                 vecs[i].e_pend, vecs[i].e_missed);
      end

      // no preemption: ID 1 held while bit 7 arrives
      step(8'h02, 8'h00, 1'b0); chk_out("nopre0", 1'b0, 3'd3, 8'h02, 8'h10);
      step(8'h00, 8'h00, 1'b0); chk_out("nopre1", 1'b1, 3'd1, 8'h02, 8'h10);
      step(8'h80, 8'h00, 1'b0); chk_out("nopre2", 1'b1, 3'd1, 8'h82, 8'h10);
      step(8'h00, 8'h00, 1'b0); chk_out("nopre3", 1'b1, 3'd1, 8'h82, 8'h10);
      step(8'h00, 8'h00, 1'b1); chk_out("nopre4", 1'b0, 3'd1, 8'h80, 8'h10);
      waited = 0;
      while (!irq_valid && waited < 4) begin
         step(8'h00, 8'h00, 1'b0);
         waited++;
      end
      chk("nopre.wait_cycles", waited, 1);
      chk_out("nopre5", 1'b1, 3'd7, 8'h80, 8'h10);
      step(8'h00, 8'h00, 1'b1); chk_out("nopre6", 1'b0, 3'd7, 8'h00, 8'h10);

      // reset while presenting discards everything
      step(8'h81, 8'h00, 1'b0); chk_out("rstp0", 1'b0, 3'd7, 8'h81, 8'h10);
      step(8'h00, 8'h00, 1'b0); chk_out("rstp1", 1'b1, 3'd7, 8'h81, 8'h10);
      rst = 1'b1;
      step(8'h00, 8'h00, 1'b0); chk_out("rstp2", 1'b0, 3'd0, 8'h00, 8'h00);
      rst = 1'b0;
      step(8'h00, 8'h00, 1'b0); chk_out("rstp3", 1'b0, 3'd0, 8'h00, 8'h00);
      step(8'h00, 8'h00, 1'b0); chk_out("rstp4", 1'b0, 3'd0, 8'h00, 8'h00);

      // line held high through reset release counts as a rise
      rst = 1'b1;
      step(8'h04, 8'h00, 1'b0); chk_out("rsth0", 1'b0, 3'd0, 8'h00, 8'h00);
      rst = 1'b0;
      step(8'h04, 8'h00, 1'b0); chk_out("rsth1", 1'b0, 3'd0, 8'h04, 8'h00);
      step(8'h04, 8'h00, 1'b0); chk_out("rsth2", 1'b1, 3'd2, 8'h04, 8'h00);
      step(8'h00, 8'h00, 1'b1); chk_out("rsth3", 1'b0, 3'd2, 8'h00, 8'h00);

      step(8'h00, 8'h00, 1'b0);
      chk("sb.leftover", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
